// File: rtl/lightsaber_pkg.sv
// Shared definitions for the lightsaber power manager.
//   - state_e    : power manager state encoding (driven on the 3-bit state output)
//   - usage_e    : blade usage level (2-bit usage input)
//   - usage_cost : per-channel drain for a usage level
//   - DEF_*      : default parameter values for the power manager
package lightsaber_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RECHARGE = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_DEPLETED = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        USE_NONE  = 2'b00,
        USE_TRAIN = 2'b01,
        USE_DUEL  = 2'b10,
        USE_CUT   = 2'b11
    } usage_e;

    localparam int unsigned DEF_MAX_CHARGE    = 255;
    localparam int unsigned DEF_WARN_LEVEL    = 32;
    localparam int unsigned DEF_RESTART_LEVEL = 64;
    localparam int unsigned DEF_RECHARGE_RATE = 2;
    localparam int unsigned DEF_COST_TRAIN    = 1;
    localparam int unsigned DEF_COST_DUEL     = 2;
    localparam int unsigned DEF_COST_CUT      = 4;

    // Drain charged per active channel per cycle at the given usage level.
    function automatic int unsigned usage_cost(
        input logic [1:0]  usage,
        input int unsigned c_train,
        input int unsigned c_duel,
        input int unsigned c_cut
    );
        case (usage_e'(usage))
            USE_TRAIN: return c_train;
            USE_DUEL:  return c_duel;
            USE_CUT:   return c_cut;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/lightsaber_power_mgr_if.sv
// Control/status bundle between the lightsaber top level and the power manager.
//   on, mode, usage, chan_en : requests from the top level (master -> slave)
//   charge, drain, chan_pwr,
//   warn, state              : registered status from the power manager (slave -> master)
interface lightsaber_power_mgr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    localparam int DW = WIDTH + $clog2(CHANNELS + 1);

    logic                on;
    logic                mode;
    logic [1:0]          usage;
    logic [CHANNELS-1:0] chan_en;
    logic [WIDTH-1:0]    charge;
    logic [DW-1:0]       drain;
    logic [CHANNELS-1:0] chan_pwr;
    logic                warn;
    logic [2:0]          state;

    modport master (
        output on, mode, usage, chan_en,
        input  charge, drain, chan_pwr, warn, state
    );

    modport slave (
        input  on, mode, usage, chan_en,
        output charge, drain, chan_pwr, warn, state
    );
endinterface

// File: rtl/lightsaber_power_mgr_channel_popcount.sv
// Combinational count of requested emitter channels.
//   chan_en_i : channel request vector (CHANNELS bits)
//   count_o   : number of set bits, $clog2(CHANNELS+1) bits wide
module channel_popcount #(
    parameter int CHANNELS = 2,
    parameter int CW       = $clog2(CHANNELS + 1)
) (
    input  logic [CHANNELS-1:0] chan_en_i,
    output logic [CW-1:0]       count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count_o = count_o + CW'(chan_en_i[i]);
        end
    end
endmodule

// File: rtl/lightsaber_power_mgr.sv
// Shared charge reservoir for a multi-channel lightsaber.
// Drains per powered channel at a usage-dependent cost, recharges with
// saturation, flags low charge and locks out after full depletion until
// the reservoir has been recharged to RESTART_LEVEL.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : slave side of lightsaber_power_mgr_if (requests in, status out)
module lightsaber_power_mgr
    import lightsaber_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter int          CHANNELS      = 2,
    parameter int unsigned MAX_CHARGE    = DEF_MAX_CHARGE,
    parameter int unsigned WARN_LEVEL    = DEF_WARN_LEVEL,
    parameter int unsigned RESTART_LEVEL = DEF_RESTART_LEVEL,
    parameter int unsigned RECHARGE_RATE = DEF_RECHARGE_RATE,
    parameter int unsigned COST_TRAIN    = DEF_COST_TRAIN,
    parameter int unsigned COST_DUEL     = DEF_COST_DUEL,
    parameter int unsigned COST_CUT      = DEF_COST_CUT
) (
    input logic                  clk,
    input logic                  rst,
    lightsaber_power_mgr_if.slave bus
);
    localparam int CW = $clog2(CHANNELS + 1);
    localparam int DW = WIDTH + CW;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    charge_q, charge_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [CHANNELS-1:0] chan_pwr_q, chan_pwr_d;
    logic                warn_q, warn_d;

    logic [CW-1:0]       active_cnt;
    logic [DW-1:0]       cost_w;
    logic [DW-1:0]       drain_w;
    logic [WIDTH:0]      sum_w;
    logic [WIDTH-1:0]    recharged_w;
    logic [WIDTH-1:0]    drained_w;

    channel_popcount #(.CHANNELS(CHANNELS), .CW(CW)) u_popcount (
        .chan_en_i (bus.chan_en),
        .count_o   (active_cnt)
    );

    // DW bits hold cost x count without loss as long as cost fits in WIDTH bits.
    assign cost_w  = DW'(usage_cost(bus.usage, COST_TRAIN, COST_DUEL, COST_CUT));
    assign drain_w = cost_w * DW'(active_cnt);

    // One extra bit catches the carry before clamping to the ceiling.
    assign sum_w       = {1'b0, charge_q} + (WIDTH + 1)'(RECHARGE_RATE);
    assign recharged_w = (sum_w > (WIDTH + 1)'(MAX_CHARGE)) ? WIDTH'(MAX_CHARGE)
                                                            : sum_w[WIDTH-1:0];

    // Compare first so the reservoir floors at zero instead of wrapping.
    assign drained_w = (drain_w >= DW'(charge_q)) ? '0
                                                  : charge_q - drain_w[WIDTH-1:0];

    always_comb begin
        // NOTE: every target gets a default before the case so no latch is inferred.
        state_d    = state_q;
        charge_d   = charge_q;
        drain_d    = '0;
        chan_pwr_d = '0;

        case (state_q)
            ST_DEPLETED: begin
                // Lockout ignores on=0 and use requests; only recharging helps.
                if (bus.on && !bus.mode) begin
                    charge_d = recharged_w;
                    if (recharged_w >= WIDTH'(RESTART_LEVEL)) begin
                        state_d = ST_RECHARGE;
                    end
                end
            end
            default: begin
                // OFF/RECHARGE/ACTIVE follow on/mode; the edge applies the
                // behaviour of the state being entered.
                if (!bus.on) begin
                    state_d = ST_OFF;
                end else if (!bus.mode) begin
                    state_d  = ST_RECHARGE;
                    charge_d = recharged_w;
                end else begin
                    charge_d = drained_w;
                    drain_d  = drain_w;
                    if (drained_w == '0) begin
                        state_d = ST_DEPLETED;
                    end else begin
                        state_d    = ST_ACTIVE;
                        chan_pwr_d = bus.chan_en;
                    end
                end
            end
        endcase

        warn_d = (charge_d <= WIDTH'(WARN_LEVEL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            charge_q   <= '0;
            drain_q    <= '0;
            chan_pwr_q <= '0;
            warn_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state_q    <= state_d;
            charge_q   <= charge_d;
            drain_q    <= drain_d;
            chan_pwr_q <= chan_pwr_d;
            warn_q     <= warn_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.charge   = charge_q;
    assign bus.drain    = drain_q;
    assign bus.chan_pwr = chan_pwr_q;
    assign bus.warn     = warn_q;
endmodule

// File: tb/tb_lightsaber_power_mgr.sv
// Self-checking bench for lightsaber_power_mgr: a default 2-channel build
// tracked every cycle by a behavioural model, plus a 4-channel / 10-bit build.
module tb_lightsaber_power_mgr;
    import lightsaber_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lightsaber_power_mgr_if #(.WIDTH(8), .CHANNELS(2))  bus  ();
    lightsaber_power_mgr_if #(.WIDTH(10), .CHANNELS(4)) bus4 ();

    lightsaber_power_mgr u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lightsaber_power_mgr #(.WIDTH(10), .CHANNELS(4), .MAX_CHARGE(1000)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Behavioural model of the default build, kept in plain integers.
    int     m_charge;
    int     m_drain;
    int     m_pwr;
    int     m_warn;
    state_e m_state;

    task automatic model_reset();
        m_charge = 0;
        m_drain  = 0;
        m_pwr    = 0;
        m_warn   = 0;
        m_state  = ST_OFF;
    endtask

    task automatic model_step();
        int cost;
        int need;
        cost = (bus.usage == 2'd0) ? 0 : (bus.usage == 2'd1) ? 1 : (bus.usage == 2'd2) ? 2 : 4;
        need = cost * $countones(bus.chan_en);
        m_drain = 0;
        m_pwr   = 0;
        if (m_state == ST_DEPLETED) begin
            if (bus.on && !bus.mode) begin
                m_charge = (m_charge + 2 > 255) ? 255 : m_charge + 2;
                if (m_charge >= 64) m_state = ST_RECHARGE;
            end
        end else if (!bus.on) begin
            m_state = ST_OFF;
        end else if (!bus.mode) begin
            m_state  = ST_RECHARGE;
            m_charge = (m_charge + 2 > 255) ? 255 : m_charge + 2;
        end else begin
            m_drain  = need;
            m_charge = (need >= m_charge) ? 0 : m_charge - need;
            if (m_charge == 0) begin
                m_state = ST_DEPLETED;
            end else begin
                m_state = ST_ACTIVE;
                m_pwr   = int'(bus.chan_en);
            end
        end
        m_warn = (m_charge <= 32) ? 1 : 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model charge",   32'(bus.charge),   32'(m_charge));
        check("model drain",    32'(bus.drain),    32'(m_drain));
        check("model chan_pwr", 32'(bus.chan_pwr), 32'(m_pwr));
        check("model warn",     32'(bus.warn),     32'(m_warn));
        check("model state",    32'(bus.state),    32'(m_state));
    endtask

    // Inputs are already driven; advance one edge and sample 1 ns after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic on, input logic mode, input logic [1:0] usage,
                         input logic [1:0] chan_en);
        bus.on      = on;
        bus.mode    = mode;
        bus.usage   = usage;
        bus.chan_en = chan_en;
    endtask

    // Called 1 ns after an edge: reset pulse entirely between edges.
    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00, 2'b00);
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    typedef struct {
        logic       on;
        logic       mode;
        logic [1:0] usage;
        logic [1:0] chan_en;
        int         reps;
        int         exp_charge;
        int         exp_drain;
        int         exp_pwr;
        int         exp_warn;
        state_e     exp_state;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00,  10,  20, 0, 0, 1, ST_RECHARGE};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 118, 255, 0, 0, 0, ST_RECHARGE};
        vecs[2]  = '{1'b1, 1'b1, 2'b11, 2'b11,   1, 247, 8, 3, 0, ST_ACTIVE};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 2'b11,  27,  31, 8, 3, 1, ST_ACTIVE};
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 2'b11,   3,   7, 8, 3, 1, ST_ACTIVE};
        vecs[5]  = '{1'b1, 1'b1, 2'b11, 2'b11,   1,   0, 8, 0, 1, ST_DEPLETED};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b00,   5,   0, 0, 0, 1, ST_DEPLETED};
        vecs[7]  = '{1'b1, 1'b1, 2'b11, 2'b11,   2,   0, 0, 0, 1, ST_DEPLETED};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 2'b00,  31,  62, 0, 0, 0, ST_DEPLETED};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 2'b00,   1,  64, 0, 0, 0, ST_RECHARGE};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b00,  18, 100, 0, 0, 0, ST_RECHARGE};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 2'b01,   1,  99, 1, 1, 0, ST_ACTIVE};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 2'b11,   1,  97, 2, 3, 0, ST_ACTIVE};
        vecs[13] = '{1'b1, 1'b1, 2'b00, 2'b11,   3,  97, 0, 3, 0, ST_ACTIVE};

        drive(1'b0, 1'b0, 2'b00, 2'b00);
        bus4.on = 1'b0; bus4.mode = 1'b0; bus4.usage = 2'b00; bus4.chan_en = 4'b0000;
        model_reset();
        #3;
        check("reset state",    32'(bus.state),    32'(ST_OFF));
        check("reset charge",   32'(bus.charge),   0);
        check("reset warn",     32'(bus.warn),     0);
        rst = 1'b1;

        // First edge after reset with empty reservoir raises warn; OFF holds.
        @(negedge clk);
        cycle();
        check("first edge warn",  32'(bus.warn),  1);
        check("first edge state", 32'(bus.state), 32'(ST_OFF));

        // Table: recharge/saturate, drain to lockout, lockout exit, drain changes.
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].on, vecs[v].mode, vecs[v].usage, vecs[v].chan_en);
            for (int r = 0; r < vecs[v].reps; r++) cycle();
            check($sformatf("vec%0d charge", v),   32'(bus.charge),   32'(vecs[v].exp_charge));
            check($sformatf("vec%0d drain", v),    32'(bus.drain),    32'(vecs[v].exp_drain));
            check($sformatf("vec%0d chan_pwr", v), 32'(bus.chan_pwr), 32'(vecs[v].exp_pwr));
            check($sformatf("vec%0d warn", v),     32'(bus.warn),     32'(vecs[v].exp_warn));
            check($sformatf("vec%0d state", v),    32'(bus.state),    32'(vecs[v].exp_state));
        end

        // Asynchronous reset while ACTIVE at 150, then restart straight into use.
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 2'b00);
        for (int r = 0; r < 75; r++) cycle();
        drive(1'b1, 1'b1, 2'b01, 2'b01);
        cycle();
        check("pre-reset charge", 32'(bus.charge), 149);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async rst state",    32'(bus.state),    32'(ST_OFF));
        check("async rst charge",   32'(bus.charge),   0);
        check("async rst drain",    32'(bus.drain),    0);
        check("async rst chan_pwr", 32'(bus.chan_pwr), 0);
        check("async rst warn",     32'(bus.warn),     0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b01, 2'b01);
        cycle();
        check("restart depleted", 32'(bus.state),  32'(ST_DEPLETED));
        check("restart charge",   32'(bus.charge), 0);

        // Wide build: saturate at 1000 without wrap, then 4 channels cutting.
        do_reset();
        bus4.on = 1'b1; bus4.mode = 1'b0; bus4.usage = 2'b00; bus4.chan_en = 4'b0000;
        for (int r = 0; r < 500; r++) cycle();
        check("wide charge 1000", 32'(bus4.charge), 1000);
        for (int r = 0; r < 3; r++) cycle();
        check("wide saturate", 32'(bus4.charge), 1000);
        check("wide warn",     32'(bus4.warn),   0);
        bus4.mode = 1'b1; bus4.usage = 2'b11; bus4.chan_en = 4'b1111;
        cycle();
        check("wide drain 16",  32'(bus4.drain),    16);
        check("wide charge",    32'(bus4.charge),   984);
        check("wide chan_pwr",  32'(bus4.chan_pwr), 15);
        check("wide state",     32'(bus4.state),    32'(ST_ACTIVE));
        bus4.on = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int r = 0; r < 2000; r++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
